// File: rtl/rvm_shift_unit.sv
// Shift functional unit (SLL/SRL/SRA/pass) that recomputes whenever its operands change; valid only while result matches inputs.
// Define RVM_SHF_BARREL_EN to compute the result with a one-cycle barrel shifter instead of STEP bits per cycle.
module rvm_shift_unit #(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] f_shf_lhs,
    input  logic [31:0] f_shf_rhs,
    input  logic [1:0]  f_shf_op,
    output logic        f_shf_valid,
    output logic [31:0] f_shf_result
);
    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        SHIFT   = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;
    localparam logic [5:0] STEP_W  = 6'(STEP);

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] tag_lhs_q, tag_lhs_d;
    logic [4:0]  tag_shamt_q, tag_shamt_d;
    logic [1:0]  tag_op_q, tag_op_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        valid_q, valid_d;

    logic        match;
    logic [4:0]  shamt;
    logic [5:0]  step_amt;
    logic        unused_rhs_hi;

    function automatic logic [31:0] shift_by(input logic [31:0] a, input logic [1:0] op,
                                             input logic [5:0] amt);
        logic [31:0] r;
        case (op)
            OP_SLL:  r = a << amt;
            OP_SRL:  r = a >> amt;
            OP_SRA:  r = $unsigned($signed(a) >>> amt);
            default: r = a;
        endcase
        return r;
    endfunction

    assign shamt         = f_shf_rhs[4:0];
    assign unused_rhs_hi = ^f_shf_rhs[31:5];

    // Upper shift-amount bits are deliberately excluded so they never trigger a recompute.
    assign match = (f_shf_lhs == tag_lhs_q) && (shamt == tag_shamt_q) && (f_shf_op == tag_op_q);

    assign f_shf_valid  = valid_q && match;
    assign f_shf_result = acc_q;

    assign step_amt = ({1'b0, cnt_q} > STEP_W) ? STEP_W : {1'b0, cnt_q};

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        tag_lhs_d   = tag_lhs_q;
        tag_shamt_d = tag_shamt_q;
        tag_op_d    = tag_op_q;
        cnt_d       = cnt_q;
        valid_d     = valid_q;
        case (state_q)
            CAPTURE: begin
                tag_lhs_d   = f_shf_lhs;
                tag_shamt_d = shamt;
                tag_op_d    = f_shf_op;
`ifdef RVM_SHF_BARREL_EN
                acc_d   = shift_by(f_shf_lhs, f_shf_op, {1'b0, shamt});
                cnt_d   = 5'd0;
                valid_d = 1'b1;
                state_d = DONE;
`else
                acc_d   = f_shf_lhs;
                cnt_d   = shamt;
                valid_d = 1'b0;
                if ((shamt == 5'd0) || (f_shf_op == OP_PASS)) begin
                    valid_d = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
`endif
            end
            SHIFT: begin
                if (!match) begin
                    state_d = CAPTURE;
                end else begin
                    acc_d = shift_by(acc_q, tag_op_q, step_amt);
                    cnt_d = cnt_q - step_amt[4:0];
                    if (cnt_d == 5'd0) begin
                        valid_d = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (!match) begin
                    valid_d = 1'b0;
                    state_d = CAPTURE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = CAPTURE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= CAPTURE;
            acc_q       <= 32'd0;
            tag_lhs_q   <= 32'd0;
            tag_shamt_q <= 5'd0;
            tag_op_q    <= 2'd0;
            cnt_q       <= 5'd0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            tag_lhs_q   <= tag_lhs_d;
            tag_shamt_q <= tag_shamt_d;
            tag_op_q    <= tag_op_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
        end
    end
endmodule

// File: tb/tb_rvm_shift_unit.sv
// Bench for rvm_shift_unit: two instances (STEP=1 and STEP=4) driven by the same directed vectors,
// checked every cycle against a latency/result model plus literal expectations from the shift examples.
module tb_rvm_shift_unit;
`ifdef RVM_SHF_BARREL_EN
    localparam bit BAR = 1'b1;
`else
    localparam bit BAR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] lhs, rhs;
    logic [1:0]  op;
    logic        v1, v4;
    logic [31:0] r1, r4;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    rvm_shift_unit #(.STEP(1)) dut1 (
        .clk(clk), .resetn(resetn), .f_shf_lhs(lhs), .f_shf_rhs(rhs), .f_shf_op(op),
        .f_shf_valid(v1), .f_shf_result(r1)
    );
    rvm_shift_unit #(.STEP(4)) dut4 (
        .clk(clk), .resetn(resetn), .f_shf_lhs(lhs), .f_shf_rhs(rhs), .f_shf_op(op),
        .f_shf_valid(v4), .f_shf_result(r4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Result computed arithmetically: shifts as multiply/divide by a power of two.
    function automatic logic [31:0] ref_res(input logic [31:0] a, input logic [4:0] s, input logic [1:0] o);
        logic [63:0] pw;
        logic [31:0] srl, keep;
        pw   = 64'd1 << s;
        srl  = 32'({32'd0, a} / pw);
        keep = 32'(64'h0000_0000_FFFF_FFFF / pw);
        case (o)
            2'b00:   return 32'({32'd0, a} * pw);
            2'b01:   return srl;
            2'b10:   return srl | (a[31] ? ~keep : 32'd0);
            default: return a;
        endcase
    endfunction

    typedef enum {M_CAP, M_BUSY, M_RDY} mode_e;
    mode_e       md [2];
    logic [31:0] cl [2];
    logic [4:0]  cs [2];
    logic [1:0]  co [2];
    int          rem[2];

    function automatic bit mmatch(input int i);
        return (lhs == cl[i]) && (rhs[4:0] == cs[i]) && (op == co[i]);
    endfunction

    function automatic int need(input int i);
        int st;
        st = (i == 0) ? 1 : 4;
        if (BAR || op == 2'b11) return 0;
        return (int'(rhs[4:0]) + st - 1) / st;
    endfunction

    // Model: capture edge, then ceil(shamt/STEP) working edges, any relevant change restarts.
    always @(posedge clk or negedge resetn) begin
        for (int i = 0; i < 2; i++) begin
            if (!resetn) begin
                md[i] <= M_CAP; cl[i] <= 32'd0; cs[i] <= 5'd0; co[i] <= 2'd0; rem[i] <= 0;
            end else begin
                case (md[i])
                    M_CAP: begin
                        cl[i]  <= lhs; cs[i] <= rhs[4:0]; co[i] <= op;
                        rem[i] <= need(i);
                        md[i]  <= (need(i) == 0) ? M_RDY : M_BUSY;
                    end
                    M_BUSY: begin
                        if (!mmatch(i)) md[i] <= M_CAP;
                        else begin
                            rem[i] <= rem[i] - 1;
                            if (rem[i] == 1) md[i] <= M_RDY;
                        end
                    end
                    default: if (!mmatch(i)) md[i] <= M_CAP;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (resetn) begin
            for (int i = 0; i < 2; i++) begin
                logic ev;
                ev = (md[i] == M_RDY) && mmatch(i);
                chk((i == 0) ? "model_vld_s1" : "model_vld_s4", (i == 0) ? {31'd0, v1} : {31'd0, v4}, {31'd0, ev});
                if (ev)
                    chk((i == 0) ? "model_res_s1" : "model_res_s4", (i == 0) ? r1 : r4,
                        ref_res(cl[i], cs[i], co[i]));
            end
        end
    end

    task automatic start(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        lhs = a; rhs = b; op = o;
        resetn = 1'b1;
    endtask

    // Cycle N is the cycle the inputs were set; checks valid=0 at N+lat-1 and the result at N+lat.
    task automatic check_lat(input string nm, input int l1, input int l4, input logic [31:0] exp);
        int mx;
        mx = (l1 > l4) ? l1 : l4;
        for (int c = 1; c <= mx; c++) begin
            @(posedge clk); @(negedge clk);
            if (c == l1 - 1) chk({nm, "_pre_s1"}, {31'd0, v1}, 32'd0);
            if (c == l4 - 1) chk({nm, "_pre_s4"}, {31'd0, v4}, 32'd0);
            if (c == l1) begin chk({nm, "_vld_s1"}, {31'd0, v1}, 32'd1); chk({nm, "_res_s1"}, r1, exp); end
            if (c == l4) begin chk({nm, "_vld_s4"}, {31'd0, v4}, 32'd1); chk({nm, "_res_s4"}, r4, exp); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; lhs = 32'd0; rhs = 32'd0; op = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld_s1", {31'd0, v1}, 32'd0);
        chk("rst_res_s1", r1, 32'd0);
        chk("rst_vld_s4", {31'd0, v4}, 32'd0);
        chk("rst_res_s4", r4, 32'd0);

        start(32'h0000_0001, 32'h0000_001F, 2'b00);
        check_lat("sll31", BAR ? 1 : 32, BAR ? 1 : 9, 32'h8000_0000);

        start(32'h8000_0000, 32'h0000_0024, 2'b10);
        check_lat("sra4", BAR ? 1 : 5, BAR ? 1 : 2, 32'hF800_0000);

        start(32'h8000_0000, 32'h0000_0024, 2'b01);
        check_lat("srl4", BAR ? 1 : 5, BAR ? 1 : 2, 32'h0800_0000);

        start(32'hDEAD_BEEF, 32'h0000_0020, 2'b01);
        check_lat("shamt0", 1, 1, 32'hDEAD_BEEF);

        start(32'h1234_5678, 32'h0000_0005, 2'b11);
        check_lat("pass", 1, 1, 32'h1234_5678);

        start(32'h0000_0001, 32'h0000_0010, 2'b00);
        repeat (5) @(posedge clk);
        #1 lhs = 32'h0000_0003;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (v1) break;
        end
        chk("abort_vld_s1", {31'd0, v1}, 32'd1);
        chk("abort_res_s1", r1, 32'h0003_0000);
        chk("abort_res_s4", r4, 32'h0003_0000);

        @(posedge clk); #1 rhs = 32'hABCD_E010;
        @(negedge clk);
        chk("rhs_hi_vld", {31'd0, v1}, 32'd1);
        chk("rhs_hi_res", r1, 32'h0003_0000);
        repeat (3) @(negedge clk);
        chk("rhs_hi_hold", {31'd0, v1}, 32'd1);

        start(32'h0000_0001, 32'h0000_001F, 2'b00);
        repeat (3) @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        chk("midrst_vld_s1", {31'd0, v1}, 32'd0);
        chk("midrst_res_s1", r1, 32'd0);
        chk("midrst_res_s4", r4, 32'd0);
        lhs = 32'h0000_00F0; rhs = 32'h0000_0004; op = 2'b01;
        @(posedge clk); #1 resetn = 1'b1;
        check_lat("rst_srl", BAR ? 1 : 5, BAR ? 1 : 2, 32'h0000_000F);

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
